// File: rtl/mpc_mul_arb_pkg.sv
// rtl/mpc_mul_arb_pkg.sv - shared operand/product widths and tag type for the multiplier arbiter
package mpc_mul_arb_pkg;

    localparam int A_W  = 16;
    localparam int B_W  = 6;
    localparam int P_W  = 22;
    localparam int ID_W = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mpc_mul_arb_rr_pick.sv
// rtl/mpc_mul_arb_rr_pick.sv - round-robin picker: first set request at or after the pointer
module mpc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mpc_mul_arb.sv
// rtl/mpc_mul_arb.sv - arbitrates NUM_REQ requesters onto one external 16s x 6u multiplier
// Optional MPC_MUL_ARB_FIXPRI_EN: requester 0 always wins, the rest round-robin.
module mpc_mul_arb
    import mpc_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 4,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int CW      = $clog2(LATENCY + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IW-1:0]          resp_id,
    output logic [P_W-1:0]         resp_p,
    output logic [CW-1:0]          inflight
);

    tag_t               tag_q [LATENCY];
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [A_W-1:0]     din0_q;
    logic [B_W-1:0]     din1_q;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [NUM_REQ-1:0] pick_req, pick_gnt, gnt;
    logic [IW-1:0]      pick_idx, gnt_idx;
    logic               accept, resp_hs;

    assign resp_valid = tag_q[LATENCY-1].valid;
    assign resp_id    = tag_q[LATENCY-1].id[IW-1:0];
    assign resp_p     = mul_dout;
    assign mul_ce     = !(resp_valid && !resp_ready);
    assign resp_hs    = resp_valid && resp_ready;
    assign mul_din0   = din0_q;
    assign mul_din1   = din1_q;
    assign inflight   = inflight_q;

    mpc_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

`ifdef MPC_MUL_ARB_FIXPRI_EN
    assign pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
    always_comb begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
        if (req_valid[0]) begin
            gnt     = NUM_REQ'(1);
            gnt_idx = '0;
        end
    end
`else
    assign pick_req = req_valid;
    assign gnt      = pick_gnt;
    assign gnt_idx  = pick_idx;
`endif

    // Reset gating keeps req_ready low while the block is held in reset.
    assign req_ready = (mul_ce && reset) ? gnt : '0;
    assign accept    = |req_ready;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !resp_hs) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!accept && resp_hs) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s] <= '0;
            end
            ptr_q      <= '0;
            din0_q     <= '0;
            din1_q     <= '0;
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            // Tags, operands and the external multiplier all freeze together on stall.
            if (mul_ce) begin
                tag_q[0] <= accept ? tag_t'{valid: 1'b1, id: ID_W'(gnt_idx)} : '0;
                for (int s = 1; s < LATENCY; s++) begin
                    tag_q[s] <= tag_q[s-1];
                end
                ptr_q <= ptr_d;
                if (accept) begin
                    din0_q <= req_a[int'(gnt_idx)*A_W +: A_W];
                    din1_q <= req_b[int'(gnt_idx)*B_W +: B_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_mpc_mul_arb.sv
// tb/tb_mpc_mul_arb.sv - randomized and directed self-checking bench for mpc_mul_arb
module tb_mpc_mul_arb;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int IW = 2;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*16-1:0] req_a;
    logic [N*6-1:0]  req_b;
    logic            mul_ce;
    logic [15:0]     mul_din0;
    logic [5:0]      mul_din1;
    logic [21:0]     mul_dout;
    logic            resp_valid, resp_ready;
    logic [IW-1:0]   resp_id;
    logic [21:0]     resp_p;
    logic [CW-1:0]   inflight;

    always #5 clk = ~clk;

    mpc_mul_arb #(.NUM_REQ(N), .LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_ce     (mul_ce),
        .mul_din0   (mul_din0),
        .mul_din1   (mul_din1),
        .mul_dout   (mul_dout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .inflight   (inflight)
    );

    // External multiplier: L-1 ce-gated stages behind the block's operand registers, never reset.
    logic signed [21:0] mpipe [L-1];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= $signed(mul_din0) * $signed({1'b0, mul_din1});
            for (int k = 1; k < L - 1; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_dout = mpipe[L-2];

    typedef struct {
        int id;
        int prod;
        int age;
    } item_t;

    item_t q[$];
    int    ptr;
    int    checks;
    int    errors;
    int    g_cur;
    bit    hs_cur, ce_cur, rst_cur;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input logic [N-1:0] v);
`ifdef MPC_MUL_ARB_FIXPRI_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
`ifdef MPC_MUL_ARB_FIXPRI_EN
            if (j == 0) continue;
`endif
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive(input bit rst, input logic [N-1:0] v, input bit rr,
                         input bit fix, input int a0, input int b0);
        bit          ev;
        logic [N-1:0] erdy;
        @(negedge clk);
        reset      = rst;
        req_valid  = v;
        resp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[6*i +: 6]   = 6'($urandom);
        end
        if (fix) begin
            req_a[15:0] = 16'(a0);
            req_b[5:0]  = 6'(b0);
        end
        if (!rst) begin
            q.delete();
            ptr = 0;
        end
        #1;
        ev      = rst && q.size() > 0 && q[0].age >= L;
        ce_cur  = !(ev && !rr);
        g_cur   = (rst && ce_cur) ? exp_grant(v) : -1;
        erdy    = (g_cur >= 0) ? (N'(1) << g_cur) : '0;
        hs_cur  = ev && rr;
        rst_cur = rst;
        chk("req_ready", req_ready, erdy);
        chk("mul_ce", mul_ce, ce_cur);
        chk("resp_valid", resp_valid, ev);
        chk("inflight", inflight, q.size());
        if (ev) begin
            chk("resp_id", resp_id, q[0].id);
            chk("resp_p", $signed(resp_p), q[0].prod);
        end
    endtask

    task automatic tick();
        item_t it;
        @(posedge clk);
        if (rst_cur) begin
            if (hs_cur) void'(q.pop_front());
            if (ce_cur) foreach (q[k]) q[k].age++;
            if (g_cur >= 0) begin
                it.id   = g_cur;
                it.prod = int'($signed(req_a[16*g_cur +: 16])) * int'(req_b[6*g_cur +: 6]);
                it.age  = 1;
                q.push_back(it);
                ptr = (g_cur + 1) % N;
            end
        end
    endtask

    task automatic single(input int a, input int b, input int exp_p);
        int n;
        drive(1, N'(1), 1, 1, a, b);
        chk("single_ready", req_ready, 1);
        tick();
        n = 1;
        drive(1, '0, 1, 0, 0, 0);
        while (!resp_valid && n < 10) begin
            tick();
            n++;
            drive(1, '0, 1, 0, 0, 0);
        end
        chk("single_latency", n, L);
        chk("single_p", $signed(resp_p), exp_p);
        chk("single_id", resp_id, 0);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, '0, 1, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        int exp_g;
        checks     = 0;
        errors     = 0;
        ptr        = 0;
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;

        drive(0, '1, 1, 0, 0, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_ce", mul_ce, 1);
        chk("rst_din0", mul_din0, 0);
        chk("rst_din1", mul_din1, 0);
        chk("rst_inflight", inflight, 0);
        tick();
        drive(0, '1, 1, 0, 0, 0);
        tick();

        single(-300, 63, -18900);
        single(-32768, 63, -2064384);
        single(32767, 63, 2064321);
        idle(2);

        drive(0, '0, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1, '1, 1, 0, 0, 0);
`ifdef MPC_MUL_ARB_FIXPRI_EN
            exp_g = 0;
`else
            exp_g = k % 4;
`endif
            chk("rr_order", req_ready, N'(1) << exp_g);
            if (k >= 4) begin
                chk("rr_inflight", inflight, 4);
                chk("rr_resp", resp_valid, 1);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, '1, 0, 0, 0, 0);
            chk("stall_ce", mul_ce, 0);
            chk("stall_ready", req_ready, 0);
            chk("stall_valid", resp_valid, 1);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1, '1, 1, 0, 0, 0);
            tick();
        end
        idle(8);

        drive(0, '0, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'b0010, 1, 0, 0, 0);
            tick();
        end
        drive(1, '0, 0, 0, 0, 0);
        chk("pre_rst_inflight", inflight, 3);
        tick();
        drive(0, '0, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1, '0, 1, 0, 0, 0);
            chk("post_rst_valid", resp_valid, 0);
            chk("post_rst_inflight", inflight, 0);
            tick();
        end

        drive(0, '0, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1, 4'b0101, 1, 0, 0, 0);
`ifdef MPC_MUL_ARB_FIXPRI_EN
            exp_g = 0;
`else
            exp_g = (k % 2 == 0) ? 0 : 2;
`endif
            chk("pair_order", req_ready, N'(1) << exp_g);
            tick();
        end
        idle(6);

        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 64) != 0, N'($urandom), ($urandom % 4) != 0, 0, 0, 0);
            tick();
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpc_mul_arb.md
MPC_MUL_ARB -- requirements
Module: mpc_mul_arb

Interface
REQ-001 SHALL: NUM_REQ, default 4, number of requesters sharing one 16s x 6ns multiplier (2..8).
REQ-002 SHALL: LATENCY, default 4, ce-qualified clock edges from accept to mul_dout valid.
REQ-003 SHALL: clk  in  1  single clock, rising edge.
REQ-004 SHALL: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL: req_valid  in  NUM_REQ  per-requester operand valid.
REQ-006 SHALL: req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 SHALL: req_a  in  NUM_REQ*16  signed operands, requester i at bits [16i+15:16i].
REQ-008 SHALL: req_b  in  NUM_REQ*6  unsigned operands, requester i at bits [6i+5:6i].
REQ-009 SHALL: mul_ce  out  1  clock enable to multiplier.
REQ-010 SHALL: mul_din0  out  16  registered signed operand to multiplier.
REQ-011 SHALL: mul_din1  out  6  registered unsigned operand to multiplier.
REQ-012 SHALL: mul_dout  in  22  signed product from multiplier.
REQ-013 SHALL: resp_valid  out  1  product valid; resp_ready  in  1  downstream accept.
REQ-014 SHALL: resp_id  out  clog2(NUM_REQ)  requester owning resp_p; resp_p  out  22  equals mul_dout.
REQ-015 SHALL: inflight  out  clog2(LATENCY+1)  count of valid tags in flight.

Function
REQ-016 SHALL: tag pipeline of LATENCY stages (valid bit + id), advancing only when mul_ce=1, aligned with multiplier stages.
REQ-017 SHALL: resp_valid = last tag stage valid; resp_id = last tag stage id.
REQ-018 SHALL: mul_ce = NOT(resp_valid AND NOT resp_ready); stall freezes tags, operand regs and multiplier together.
REQ-019 SHALL: grant at most one requester per cycle, only when mul_ce=1; req_ready[i]=1 exactly for granted i with req_valid[i]=1.
REQ-020 SHALL: accept (req_valid[i] AND req_ready[i]) at edge E loads mul_din0/mul_din1 and stage-1 tag {1,i}; product on resp_p with resp_valid=1 after edge E+LATENCY-1 ce-edges further (LATENCY ce-edges total).
REQ-021 SHALL: no accept with mul_ce=1 loads stage-1 tag valid=0 (bubble); operand regs hold value.
REQ-022 SHALL: round-robin: search starts at pointer, pointer becomes granted index+1 mod NUM_REQ on accept, unchanged otherwise.
REQ-023 SHALL: sustained throughput one product per cycle while resp_ready=1; products returned in accept order.
REQ-024 SHALL: inflight increments on accept, decrements on resp handshake, unchanged when both or neither occur.
REQ-025 SHALL: simultaneous resp handshake and new accept in same cycle both complete.
REQ-026 SHALL: resp_p carried width 22, no truncation or saturation in this block.

Reset
REQ-027 SHALL: on reset low: all tag valids 0, ids 0, pointer 0, mul_din0/mul_din1 0, inflight 0; hence resp_valid 0, req_ready 0 during reset, mul_ce 1.
REQ-028 SHALL: reset mid-operation discards all in-flight products; stale multiplier data is never flagged valid after release.

Configuration
REQ-029 SHALL: macro MPC_MUL_ARB_FIXPRI_EN defined: requester 0 always wins when valid, others round-robin among themselves; undefined: pure round-robin per REQ-022.

Structure
REQ-030 SHALL: shared package holds operand/product widths (16, 6, 22) and tag struct {valid, id}.
REQ-031 SHALL: one sub-module mpc_rr_pick (request vector + pointer -> one-hot grant + index).
REQ-032 SHALL: multiplier instantiated outside; this block owns only control, operand regs and tags.

Verification
REQ-033 SHALL: single req0 a=-300,b=63 -> resp_valid exactly 4 cycles after accept, resp_p=-18900, resp_id=0.
REQ-034 SHALL: all 4 requesters valid continuously -> grant order 0,1,2,3,0,...; one resp per cycle after fill; inflight=4 steady.
REQ-035 SHALL: resp_ready low 3 cycles with pipeline full -> mul_ce=0, req_ready=0, resp_p/resp_id stable; resumes with no loss or duplication.
REQ-036 SHALL: reset asserted with inflight=3 -> after release resp_valid stays 0 until new accept; inflight=0.
REQ-037 SHALL: MPC_MUL_ARB_FIXPRI_EN, req0 and req2 valid continuously -> req0 granted every cycle; macro undefined -> alternate 0,2.
REQ-038 SHALL: a=-32768,b=63 -> resp_p=-2064384; a=32767,b=63 -> resp_p=2064321.
